// File: rtl/instr_encode_loader_pkg.sv
// Shared mini-MIPS instruction format constants, ALU op and class codes,
// loader FSM states and the alu_op -> funct lookup used by encoder and decoder.
package instr_encode_loader_pkg;

   localparam logic [5:0] OP_R_TYPE      = 6'h00;
   localparam logic [5:0] OP_LOAD_TYPE   = 6'h23;
   localparam logic [5:0] OP_STORE_TYPE  = 6'h2B;
   localparam logic [5:0] OP_BRANCH_TYPE = 6'h04;
   localparam logic [5:0] OP_JUMP_TYPE   = 6'h02;
   localparam logic [5:0] OP_JAL_TYPE    = 6'h03;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SLA  = 6'h01;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MADD = 6'h1C;
   localparam logic [5:0] FUNCT_MUL  = 6'h18;
   localparam logic [5:0] FUNCT_NOT  = 6'h27;

   typedef enum logic [2:0] {
      CLS_R      = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_BRANCH = 3'd3,
      CLS_JUMP   = 3'd4,
      CLS_JAL    = 3'd5
   } instr_class_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SLA  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_MADD = 4'd10,
      ALU_MUL  = 4'd11,
      ALU_NOT  = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } load_state_e;

   typedef struct packed {
      logic       legal;
      logic [5:0] funct;
   } funct_lookup_t;

   function automatic funct_lookup_t alu_funct(input logic [3:0] alu_op);
      funct_lookup_t r;
      case (alu_op)
         ALU_ADD:  r = {1'b1, FUNCT_ADD};
         ALU_SUB:  r = {1'b1, FUNCT_SUB};
         ALU_AND:  r = {1'b1, FUNCT_AND};
         ALU_OR:   r = {1'b1, FUNCT_OR};
         ALU_XOR:  r = {1'b1, FUNCT_XOR};
         ALU_SLL:  r = {1'b1, FUNCT_SLL};
         ALU_SRL:  r = {1'b1, FUNCT_SRL};
         ALU_SLA:  r = {1'b1, FUNCT_SLA};
         ALU_SRA:  r = {1'b1, FUNCT_SRA};
         ALU_SLT:  r = {1'b1, FUNCT_SLT};
         ALU_MADD: r = {1'b1, FUNCT_MADD};
         ALU_MUL:  r = {1'b1, FUNCT_MUL};
         ALU_NOT:  r = {1'b1, FUNCT_NOT};
         default:  r = {1'b0, 6'h00};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_encode_loader_field_encoder.sv
// Combinational field encoder: decoded class/fields plus the write pc in,
// 32-bit instruction word and illegal / jump-range flags out.
module instr_field_encoder
   import instr_encode_loader_pkg::*;
(
   input  logic [2:0]  cls,
   input  logic [3:0]  alu_op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [31:0] target,
   input  logic [31:0] pc,
   output logic [31:0] word,
   output logic        illegal,
   output logic        range_err
);

   logic [31:0]   next_pc_s;
   funct_lookup_t funct_s;
   logic          target_ok_s;

   assign next_pc_s   = pc + 32'd4;
   assign funct_s     = alu_funct(alu_op);
   // J-format can only reach targets in the same 256 MB region as pc+4
   assign target_ok_s = (target[1:0] == 2'b00) && (target[31:28] == next_pc_s[31:28]);

   // Assemble the instruction word for the selected class
   always_comb begin
      word      = 32'h0000_0000;
      illegal   = 1'b0;
      range_err = 1'b0;
      case (cls)
         CLS_R: begin
            if (funct_s.legal) begin
               word = {OP_R_TYPE, rs, rt, rd, shamt, funct_s.funct};
            end else begin
               illegal = 1'b1;
            end
         end
         CLS_LOAD:   word = {OP_LOAD_TYPE, rs, rt, imm};
         CLS_STORE:  word = {OP_STORE_TYPE, rs, rt, imm};
         CLS_BRANCH: word = {OP_BRANCH_TYPE, rs, rt, imm};
         CLS_JUMP: begin
            word      = {OP_JUMP_TYPE, target[27:2]};
            range_err = !target_ok_s;
         end
         CLS_JAL: begin
            word      = {OP_JAL_TYPE, target[27:2]};
            range_err = !target_ok_s;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Boot/self-test program loader: encodes field bundles into mini-MIPS words
// and writes them to instruction memory at consecutive word addresses.
module instr_encode_loader
   import instr_encode_loader_pkg::*;
#(
   parameter int          IMEM_AW      = 10,
   parameter logic [31:0] BASE_DEFAULT = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [31:0]        start_base,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [2:0]         in_class,
   input  logic [3:0]         in_alu_op,
   input  logic [4:0]         in_rs,
   input  logic [4:0]         in_rt,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_shamt,
   input  logic [15:0]        in_imm,
   input  logic [31:0]        in_target,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err_illegal,
   output logic               err_range,
   output logic [IMEM_AW:0]   count
);

   localparam logic [IMEM_AW-1:0] PTR_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};
   localparam logic [IMEM_AW-1:0] PTR_MAX = {IMEM_AW{1'b1}};
   localparam logic [IMEM_AW:0]   CNT_ONE = {{IMEM_AW{1'b0}}, 1'b1};

   load_state_e        state_r;
   logic [IMEM_AW-1:0] ptr_r;
   logic               last_r;
   logic               armed_r;

   logic [31:0] base_s;
   logic [31:0] pc_s;
   logic [31:0] enc_word_s;
   logic        enc_illegal_s;
   logic        enc_range_s;
   logic        handshake_s;
   logic        unused_base_s;

   assign base_s        = (start_base == 32'h0000_0000) ? BASE_DEFAULT : start_base;
   assign unused_base_s = ^{base_s[31:IMEM_AW+2], base_s[1:0]};
   assign pc_s          = {{(30-IMEM_AW){1'b0}}, ptr_r, 2'b00};
   assign handshake_s   = in_valid & in_ready;
   assign imem_addr     = ptr_r;

   instr_field_encoder u_encoder (
      .cls       (in_class),
      .alu_op    (in_alu_op),
      .rs        (in_rs),
      .rt        (in_rt),
      .rd        (in_rd),
      .shamt     (in_shamt),
      .imm       (in_imm),
      .target    (in_target),
      .pc        (pc_s),
      .word      (enc_word_s),
      .illegal   (enc_illegal_s),
      .range_err (enc_range_s)
   );

   // Load session FSM with pointer, counter and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         ptr_r       <= {IMEM_AW{1'b0}};
         last_r      <= 1'b0;
         armed_r     <= 1'b0;
         in_ready    <= 1'b0;
         imem_we     <= 1'b0;
         imem_wdata  <= 32'h0000_0000;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         err_range   <= 1'b0;
         count       <= {(IMEM_AW+1){1'b0}};
      end else begin
         // armed_r masks a start coinciding with the first edge after reset
         armed_r <= 1'b1;
         case (state_r)
            ST_IDLE: begin
               if (start && armed_r) begin
                  ptr_r       <= base_s[IMEM_AW+1:2];
                  count       <= {(IMEM_AW+1){1'b0}};
                  done        <= 1'b0;
                  err_illegal <= 1'b0;
                  err_range   <= 1'b0;
                  busy        <= 1'b1;
                  in_ready    <= 1'b1;
                  state_r     <= ST_ACCEPT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCEPT: begin
               if (handshake_s) begin
                  imem_wdata  <= enc_word_s;
                  last_r      <= in_last;
                  err_illegal <= err_illegal | enc_illegal_s;
                  err_range   <= err_range | enc_range_s;
                  in_ready    <= 1'b0;
                  imem_we     <= 1'b1;
                  state_r     <= ST_WRITE;
               end else begin
                  state_r <= ST_ACCEPT;
               end
            end
            ST_WRITE: begin
               imem_we <= 1'b0;
               count   <= count + CNT_ONE;
               ptr_r   <= ptr_r + PTR_ONE;
               if (last_r) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_DONE;
               end else if (ptr_r == PTR_MAX) begin
                  err_range <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= ST_DONE;
               end else begin
                  in_ready <= 1'b1;
                  state_r  <= ST_ACCEPT;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               in_ready <= 1'b0;
               imem_we  <= 1'b0;
               busy     <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: directed bundles push expected
// memory writes; per-DUT monitors pop and compare on every imem_we.
module tb_instr_encode_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_a, start_b;
   logic [31:0] start_base;
   logic        in_valid, in_last;
   logic [2:0]  in_class;
   logic [3:0]  in_alu_op;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [31:0] in_target;

   logic        in_ready_a, imem_we_a, busy_a, done_a, err_illegal_a, err_range_a;
   logic [9:0]  imem_addr_a;
   logic [31:0] imem_wdata_a;
   logic [10:0] count_a;

   logic        in_ready_b, imem_we_b, busy_b, done_b, err_illegal_b, err_range_b;
   logic [1:0]  imem_addr_b;
   logic [31:0] imem_wdata_b;
   logic [2:0]  count_b;

   logic        sel;
   logic        cur_ready, cur_done;
   logic [63:0] q_a[$];
   logic [63:0] q_b[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          t_start = 0;
   int          t_done = 0;

   assign cur_ready = sel ? in_ready_b : in_ready_a;
   assign cur_done  = sel ? done_b : done_a;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   instr_encode_loader #(.IMEM_AW(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .start_base(start_base),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
      .in_class(in_class), .in_alu_op(in_alu_op), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
      .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
      .busy(busy_a), .done(done_a), .err_illegal(err_illegal_a),
      .err_range(err_range_a), .count(count_a)
   );

   instr_encode_loader #(.IMEM_AW(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .start_base(start_base),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
      .in_class(in_class), .in_alu_op(in_alu_op), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
      .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
      .busy(busy_b), .done(done_b), .err_illegal(err_illegal_b),
      .err_range(err_range_b), .count(count_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor for the 10-bit-address instance
   always @(negedge clk) begin
      if (imem_we_a === 1'b1) begin
         if (q_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write_a: got addr %h data %h expected no write",
                     imem_addr_a, imem_wdata_a);
         end else begin
            logic [63:0] e;
            e = q_a.pop_front();
            check("wr_addr_a", {22'h0, imem_addr_a}, e[63:32]);
            check("wr_data_a", imem_wdata_a, e[31:0]);
            check("ready_in_write_a", {31'h0, in_ready_a}, 32'h0);
         end
      end
   end

   // Monitor for the 2-bit-address instance
   always @(negedge clk) begin
      if (imem_we_b === 1'b1) begin
         if (q_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write_b: got addr %h data %h expected no write",
                     imem_addr_b, imem_wdata_b);
         end else begin
            logic [63:0] e;
            e = q_b.pop_front();
            check("wr_addr_b", {30'h0, imem_addr_b}, e[63:32]);
            check("wr_data_b", imem_wdata_b, e[31:0]);
            check("ready_in_write_b", {31'h0, in_ready_b}, 32'h0);
         end
      end
   end

   task automatic do_start(input logic use_b, input logic [31:0] base);
      @(negedge clk);
      sel        = use_b;
      start_base = base;
      if (use_b) start_b = 1'b1;
      else       start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      t_start = cyc;
   endtask

   task automatic send(input logic [2:0] cls, input logic [3:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [31:0] tgt,
                       input logic last, input logic push,
                       input logic [31:0] exp_addr, input logic [31:0] exp_word,
                       input logic abort);
      in_class = cls; in_alu_op = alu; in_rs = rs; in_rt = rt; in_rd = rd;
      in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (cur_ready) break;
         @(negedge clk);
      end
      if (!cur_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL handshake_timeout: got in_ready=0 expected 1 within 20 cycles");
         in_valid = 1'b0;
      end else begin
         if (push) begin
            if (sel) q_b.push_back({exp_addr, exp_word});
            else     q_a.push_back({exp_addr, exp_word});
         end
         @(posedge clk);
         if (abort) begin
            #2;
            rst_n = 1'b0;
         end else begin
            @(negedge clk);
         end
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         if (cur_done) break;
         @(negedge clk);
      end
      t_done = cyc;
      check("done_seen", {31'h0, cur_done}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] b_words [4];
      b_words[0] = 32'h0022_0020;
      b_words[1] = 32'h0022_0820;
      b_words[2] = 32'h0022_1020;
      b_words[3] = 32'h0022_1820;

      rst_n = 1'b0; start_a = 1'b1; start_b = 1'b0; start_base = 32'h0;
      in_valid = 1'b0; in_last = 1'b0; in_class = 3'd0; in_alu_op = 4'd0;
      in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
      in_imm = 16'h0; in_target = 32'h0; sel = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_we", {31'h0, imem_we_a}, 32'h0);
      check("rst_busy", {31'h0, busy_a}, 32'h0);
      check("rst_done", {31'h0, done_a}, 32'h0);
      check("rst_errs", {30'h0, err_illegal_a, err_range_a}, 32'h0);
      check("rst_count", {21'h0, count_a}, 32'h0);
      check("rst_ready", {31'h0, in_ready_a}, 32'h0);
      // start held across reset release must be ignored
      rst_n = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("start_at_release_busy", {31'h0, busy_a}, 32'h0);
      check("start_at_release_ready", {31'h0, in_ready_a}, 32'h0);

      // R ADD at byte base 0x40
      do_start(1'b0, 32'h0000_0040);
      send(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b1, 1'b1,
           32'h10, 32'h0022_1820, 1'b0);
      wait_done();
      check("t1_count", {21'h0, count_a}, 32'h1);
      check("t1_errs", {30'h0, err_illegal_a, err_range_a}, 32'h0);
      check("t1_busy", {31'h0, busy_a}, 32'h0);

      // LOAD then BRANCH, with an ignored start while busy
      do_start(1'b0, 32'h0);
      send(3'd1, 4'd0, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFC, 32'h0, 1'b0, 1'b1,
           32'h0, 32'h8C85_FFFC, 1'b0);
      check("t2_busy_mid", {31'h0, busy_a}, 32'h1);
      start_base = 32'h0000_0100;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      send(3'd3, 4'd0, 5'd6, 5'd7, 5'd0, 5'd0, 16'h0002, 32'h0, 1'b1, 1'b1,
           32'h1, 32'h10C7_0002, 1'b0);
      wait_done();
      check("t2_start_to_done", t_done - t_start, 32'd4);
      check("t2_count", {21'h0, count_a}, 32'h2);
      check("t2_errs", {30'h0, err_illegal_a, err_range_a}, 32'h0);

      // JUMP in range, then out of region
      do_start(1'b0, 32'h0);
      send(3'd4, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0000_0100, 1'b0, 1'b1,
           32'h0, 32'h0800_0040, 1'b0);
      check("t3_range_ok", {31'h0, err_range_a}, 32'h0);
      send(3'd4, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0100, 1'b1, 1'b1,
           32'h1, 32'h0800_0040, 1'b0);
      wait_done();
      check("t3_range_err", {31'h0, err_range_a}, 32'h1);
      check("t3_illegal", {31'h0, err_illegal_a}, 32'h0);

      // STORE, JAL, SLL at base 0x20; errors from the last session cleared
      do_start(1'b0, 32'h0000_0020);
      check("t3b_err_cleared", {31'h0, err_range_a}, 32'h0);
      send(3'd2, 4'd0, 5'd8, 5'd9, 5'd0, 5'd0, 16'h0010, 32'h0, 1'b0, 1'b1,
           32'h8, 32'hAD09_0010, 1'b0);
      send(3'd5, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0000_0200, 1'b0, 1'b1,
           32'h9, 32'h0C00_0080, 1'b0);
      send(3'd0, 4'd5, 5'd0, 5'd2, 5'd4, 5'd3, 16'h0, 32'h0, 1'b1, 1'b1,
           32'hA, 32'h0002_20C0, 1'b0);
      wait_done();
      check("t3b_count", {21'h0, count_a}, 32'h3);
      check("t3b_errs", {30'h0, err_illegal_a, err_range_a}, 32'h0);

      // illegal alu_op, then illegal class
      do_start(1'b0, 32'h0);
      send(3'd0, 4'd14, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0, 1'b1,
           32'h0, 32'h0, 1'b0);
      check("t4_illegal_mid", {31'h0, err_illegal_a}, 32'h1);
      send(3'd6, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234, 32'h0, 1'b1, 1'b1,
           32'h1, 32'h0, 1'b0);
      wait_done();
      check("t4_count", {21'h0, count_a}, 32'h2);
      check("t4_range", {31'h0, err_range_a}, 32'h0);

      // overflow on a 4-word memory
      do_start(1'b1, 32'h0);
      for (int k = 0; k < 4; k++) begin
         send(3'd0, 4'd0, 5'd1, 5'd2, 5'(k), 5'd0, 16'h0, 32'h0, 1'b0, 1'b1,
              32'(k), b_words[k], 1'b0);
      end
      wait_done();
      in_class = 3'd0; in_last = 1'b1; in_valid = 1'b1;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check("t5_ready", {31'h0, in_ready_b}, 32'h0);
      check("t5_count", {29'h0, count_b}, 32'h4);
      check("t5_range", {31'h0, err_range_b}, 32'h1);
      check("t5_illegal", {31'h0, err_illegal_b}, 32'h0);
      check("t5_busy", {31'h0, busy_b}, 32'h0);

      // reset during WRITE, then a fresh session
      do_start(1'b0, 32'h0);
      send(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0, 1'b1,
           32'h0, 32'h0022_1820, 1'b0);
      send(3'd1, 4'd0, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 32'h0, 1'b0, 1'b0,
           32'h0, 32'h0, 1'b1);
      #1;
      check("t6_we_async", {31'h0, imem_we_a}, 32'h0);
      check("t6_busy_async", {31'h0, busy_a}, 32'h0);
      check("t6_count_async", {21'h0, count_a}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_start(1'b0, 32'h0000_0008);
      send(3'd0, 4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b1, 1'b1,
           32'h2, 32'h0022_1822, 1'b0);
      wait_done();
      check("t6_count", {21'h0, count_a}, 32'h1);
      check("t6_errs", {30'h0, err_illegal_a, err_range_a}, 32'h0);

      repeat (3) @(negedge clk);
      check("queue_a_empty", q_a.size(), 32'd0);
      check("queue_b_empty", q_b.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the ID-stage instruction decoder: turns decoded fields (class, alu_op, register addresses, shamt, immediate, jump target) back into 32-bit mini-MIPS instruction words.
- Streams the encoded words into instruction memory at consecutive word addresses from a base address.
- Used by the boot/self-test path to load programs without an external assembler, and by the verification team to round-trip-check the decoder.

Parameters:
- IMEM_AW, 10, instruction memory word-address width; capacity is 2**IMEM_AW words.
- BASE_DEFAULT, 32'h0000_0000, byte load address used when start_base is not driven (tied 0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session
- start_base  in  32  byte base address, sampled on start; bits [1:0] ignored
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_last  in  1  bundle is the final instruction of the session
- in_class  in  3  0=R, 1=LOAD, 2=STORE, 3=BRANCH, 4=JUMP, 5=JAL; others illegal
- in_alu_op  in  4  ALU op code, same encoding as the decoder output
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register addresses and shift amount
- in_imm  in  16  immediate / branch offset
- in_target  in  32  absolute byte target for JUMP/JAL
- imem_we  out  1  write strobe
- imem_addr  out  IMEM_AW  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session active
- done  out  1  sticky; set on session end
- err_illegal  out  1  sticky; illegal class or alu_op
- err_range  out  1  sticky; jump target unreachable or memory overflow
- count  out  IMEM_AW+1  words written this session

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- FSM: IDLE -> ACCEPT on start.
  - On start, clear done/err_*/count and set word pointer = start_base[IMEM_AW+1:2].
  - In ACCEPT, in_ready=1; a handshake (in_valid & in_ready) registers the encoded word and moves to WRITE.
  - In WRITE, in_ready=0 and imem_we=1 for exactly one cycle with the current pointer and word. Then count+1 and pointer+1.
  - After WRITE: back to ACCEPT, or to DONE if the last accepted bundle had in_last=1.
  - DONE sets done=1, busy=0, returns to IDLE the next cycle.
- Throughput and latency: one instruction per 2 cycles. imem_we is asserted the cycle after the handshake.
- Encoding:
  - R: {OP_R_TYPE, rs, rt, rd, shamt, funct(alu_op)}.
  - LOAD/STORE/BRANCH: {opcode, rs, rt, imm}.
  - JUMP/JAL: {opcode, in_target[27:2]}.
- alu_op->funct map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLA, 8 SRA, 9 SLT, 10 MADD, 11 MUL, 12 NOT, using the shared FUNCT_* constants. alu_op 13-15 is illegal.
- Illegal class or alu_op: write 32'h0000_0000 in place of the instruction, set err_illegal, continue the session.
- Jump range check: if in_target[1:0]!=0 or in_target[31:28] != (pc+4)[31:28], set err_range but still write the truncated word. pc = pointer*4.
- Overflow: if the pointer wraps past 2**IMEM_AW-1 after a write and in_last=0, set err_range and go to DONE. No further writes.
- start while busy is ignored. start in the same cycle as reset release is ignored.
- Reset mid-session aborts immediately; imem_we drops asynchronously.
- in_valid in IDLE/WRITE/DONE is not accepted (in_ready=0); bundle fields must stay stable while in_valid=1.

Decomposition:
- Shared package/include, extending instruction_formats.v: OP_*/FUNCT_* constants, the ALU op codes, and the class codes above.
- The decoder takes its ALU localparams from the same package.
- One sub-module: instr_field_encoder. It is purely combinational: class, fields and pc in -> word, illegal and range_err out. The FSM, pointer and counters live in the top.

Test Plan:
- start_base=0x40; R ADD rs=1 rt=2 rd=3 with in_last -> one imem_we at addr 0x10, wdata={OP_R_TYPE,1,2,3,0,FUNCT_ADD}, count=1, done=1, no errors.
- LOAD rs=4 rt=5 imm=0xFFFC, then BRANCH imm=0x0002 with in_last -> writes at addr 0,1, fields exact, ~4 cycles start-to-done, in_ready low during WRITE.
- JUMP target 0x0000_0100 at pointer 0 -> wdata={OP_JUMP_TYPE,26'h40}. Then target 0x1000_0100 -> same low bits written, err_range=1.
- R with alu_op=14 -> wdata=0, err_illegal=1, session completes, count increments.
- IMEM_AW=2, base 0, 5 bundles with last on the 5th -> 4 writes, err_range=1, done after the 4th, the 5th is never accepted.
- Assert rst_n low during a WRITE cycle -> imem_we, busy and count go 0 immediately; a fresh start afterwards works normally.
